// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM states, BCD nibble geometry and the
// ordering of digits inside the packed 24-bit display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int NIBBLE_W   = 4;
  localparam int MOD_DEC    = 10;
  localparam int MOD_SEX    = 6;
  localparam int NUM_DIGITS = 6;

  // Nibble index within the display word, LSB nibble first.
  localparam int DIG_CS_U  = 0;
  localparam int DIG_CS_T  = 1;
  localparam int DIG_SEC_U = 2;
  localparam int DIG_SEC_T = 3;
  localparam int DIG_MIN_U = 4;
  localparam int DIG_MIN_T = 5;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  function automatic int digit_modulus(input int idx);
    return (idx == DIG_SEC_T) ? MOD_SEX : MOD_DEC;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Tick/control inputs and display outputs of the stopwatch, bundled so the
// driver side and the counter side each see their own direction view.
interface stopwatch_bcd_if;
  import stopwatch_pkg::*;

  logic                           tick_in;
  logic                           start_stop;
  logic                           clear;
  logic                           lap;
  logic [NUM_DIGITS*NIBBLE_W-1:0] digits;
  logic                           running;
  logic                           lap_hold;
  logic                           overflow;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  digits, running, lap_hold, overflow
  );

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output digits, running, lap_hold, overflow
  );

endinterface

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit of the stopwatch chain; carry is combinational so the whole
// chain resolves in the same cycle as the increment.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = MOD_DEC
) (
  input  logic    clkin,
  input  logic    reset,
  input  logic    clr,
  input  logic    inc,
  output nibble_t q,
  output logic    carry
);

  localparam nibble_t LAST = nibble_t'(MODULUS - 1);

  always_ff @(posedge clkin) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == LAST) ? '0 : q + nibble_t'(1);
    end
  end

  assign carry = inc & (q == LAST);

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch: synchronised tick enable, IDLE/RUN/PAUSE control, six-digit BCD
// elapsed time with a MAX_MIN wrap, lap freeze and sticky overflow.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 99
) (
  input logic           clkin,
  input logic           reset,
  stopwatch_bcd_if.slave sw
);

  localparam int      DISP_W    = NUM_DIGITS * NIBBLE_W;
  localparam nibble_t MAX_MIN_T = nibble_t'(MAX_MIN / 10);
  localparam nibble_t MAX_MIN_U = nibble_t'(MAX_MIN % 10);

  // Stage p0/p1: tick synchroniser, edge detect and registered tick pulse
  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   tick_last_p0;
  logic                   tick_pulse_p1;

  always_ff @(posedge clkin) begin
    if (reset) begin
      tick_sync     <= '0;
      tick_last_p0  <= 1'b0;
      tick_pulse_p1 <= 1'b0;
    end else begin
      tick_sync     <= {tick_sync[SYNC_STAGES-2:0], sw.tick_in};
      tick_last_p0  <= tick_sync[SYNC_STAGES-1];
      tick_pulse_p1 <= tick_sync[SYNC_STAGES-1] & ~tick_last_p0;
    end
  end

  // Stage p0/p1: control inputs registered once, then edge detected
  logic [2:0] ctl_p0;
  logic [2:0] ctl_p1;
  logic       ss_evt;
  logic       clr_evt;
  logic       lap_evt;

  always_ff @(posedge clkin) begin
    if (reset) begin
      ctl_p0 <= '0;
      ctl_p1 <= '0;
    end else begin
      ctl_p0 <= {sw.lap, sw.clear, sw.start_stop};
      ctl_p1 <= ctl_p0;
    end
  end

  assign ss_evt  = ctl_p0[0] & ~ctl_p1[0];
  assign clr_evt = ctl_p0[1] & ~ctl_p1[1];
  assign lap_evt = ctl_p0[2] & ~ctl_p1[2];

  // Run-state machine
  state_t state;
  state_t state_nxt;
  logic   is_run;

  always_ff @(posedge clkin) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr_evt) begin
      state_nxt = ST_IDLE;
    end else if (ss_evt) begin
      case (state)
        ST_IDLE:  state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    is_run = 1'b0;
    if (state == ST_RUN) is_run = 1'b1;
  end

  // Gating on the current state counts a tick that coincides with a pause
  // edge and drops one that coincides with a resume edge.
  logic              count_en;
  logic              min_at_max;
  logic              wrap;
  logic              clr_cnt;
  logic [DISP_W-1:0] live;

  assign count_en = tick_pulse_p1 & is_run;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic    inc_d;
    logic    carry_d;
    nibble_t q_d;

    if (g == 0) begin : g_first
      assign inc_d = count_en;
    end else begin : g_next
      assign inc_d = g_digit[g-1].carry_d;
    end

    bcd_digit_counter #(
      .MODULUS (digit_modulus(g))
    ) u_digit (
      .clkin (clkin),
      .reset (reset),
      .clr   (clr_cnt),
      .inc   (inc_d),
      .q     (q_d),
      .carry (carry_d)
    );

    assign live[g*NIBBLE_W +: NIBBLE_W] = q_d;
  end

  assign min_at_max = (live[DIG_MIN_T*NIBBLE_W +: NIBBLE_W] == MAX_MIN_T) &&
                      (live[DIG_MIN_U*NIBBLE_W +: NIBBLE_W] == MAX_MIN_U);
  assign wrap       = (g_digit[DIG_SEC_T].carry_d & min_at_max) |
                      g_digit[DIG_MIN_T].carry_d;
  assign clr_cnt    = clr_evt | wrap;

  // Lap freeze and sticky overflow; clear has priority over both
  logic              hold;
  logic              ovf;
  logic [DISP_W-1:0] lap_reg;

  always_ff @(posedge clkin) begin
    if (reset) begin
      hold <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr_evt) begin
      hold <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (wrap) ovf <= 1'b1;
      if (lap_evt) begin
        if (hold && state != ST_IDLE) hold <= 1'b0;
        else if (!hold && is_run)     hold <= 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (lap_evt && !hold && is_run && !clr_evt) lap_reg <= live;
  end

  assign sw.digits   = hold ? lap_reg : live;
  assign sw.running  = is_run;
  assign sw.lap_hold = hold;
  assign sw.overflow = ovf;

endmodule
